// File: rtl/perf_monitor.sv
// Performance monitor: weighted event counters plus a cycle counter, frozen once the fetched instruction stops changing.
// Latency: counters update on the enabled edge; rd_data is registered, one cycle after rd_addr.
// Backpressure: none; the block samples every edge and never stalls its source.
//
// Ports:
//   CLK, nrst        clock, synchronous active-low reset
//   en, clr          counting enable, synchronous clear (returns to RUN)
//   sat_mode         0 = counters wrap, 1 = counters saturate
//   evt_inc          2 bits per event channel, adds 0..3 per edge
//   inst, inst_valid instruction word in IF for completion detection
//   rd_addr/rd_data  registered read port (events, raw cycles, adjusted cycles)
//   ovf              sticky overflow flags, MSB is the cycle counter
//   done             completion detected, counters frozen
module perf_monitor #(
  parameter int NUM_EVT     = 8,
  parameter int CNT_W       = 32,
  parameter int INST_W      = 32,
  parameter int IDLE_THRESH = 50,
  parameter int AW          = 4
) (
  input  logic                   CLK,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   sat_mode,
  input  logic [2*NUM_EVT-1:0]   evt_inc,
  input  logic [INST_W-1:0]      inst,
  input  logic                   inst_valid,
  input  logic [AW-1:0]          rd_addr,
  output logic [CNT_W-1:0]       rd_data,
  output logic [NUM_EVT:0]       ovf,
  output logic                   done
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [NUM_EVT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]              cyc_q, cyc_d;
  logic [NUM_EVT:0]              ovf_q, ovf_d;
  logic [15:0]                   match_q, match_d;
  logic [INST_W-1:0]             last_q, last_d;
  logic [0:0]                    state_q, state_d;
  logic [CNT_W-1:0]              rd_q, rd_d;

  // Returns {overflow, next value}; the sum is formed one bit wider so the
  // carry-out is the overflow indication.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v,
                                          input logic [1:0]       inc,
                                          input logic             sat);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
    if (s[CNT_W] && sat) begin
      s = {1'b1, {CNT_W{1'b1}}};
    end
    return s;
  endfunction

  always_comb begin
    logic [CNT_W:0] r;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    ovf_d   = ovf_q;
    match_d = match_q;
    last_d  = last_q;
    state_d = state_q;
    rd_d    = '0;
    r       = '0;

    // Read mux works on the pre-update values, including on a clr edge.
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_addr == AW'(i)) rd_d = cnt_q[i];
    end
    if (rd_addr == AW'(NUM_EVT)) rd_d = cyc_q;
    if (rd_addr == AW'(NUM_EVT + 1)) begin
      rd_d = (cyc_q >= CNT_W'(IDLE_THRESH)) ? (cyc_q - CNT_W'(IDLE_THRESH)) : '0;
    end

    if (clr) begin
      cnt_d   = '0;
      cyc_d   = '0;
      ovf_d   = '0;
      match_d = '0;
      last_d  = '0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && en) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        r        = bump(cnt_q[i], evt_inc[2*i +: 2], sat_mode);
        cnt_d[i] = r[CNT_W-1:0];
        if (r[CNT_W]) ovf_d[i] = 1'b1;
      end
      r     = bump(cyc_q, 2'd1, sat_mode);
      cyc_d = r[CNT_W-1:0];
      if (r[CNT_W]) ovf_d[NUM_EVT] = 1'b1;

      // The edge that reaches the threshold still counts above; freezing
      // starts on the following edge because state only changes here.
      if (inst_valid) begin
        if (inst == last_q) begin
          match_d = match_q + 16'd1;
          if (match_d == 16'(IDLE_THRESH)) state_d = ST_DONE;
        end else begin
          last_d  = inst;
          match_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      cnt_q   <= '0;
      cyc_q   <= '0;
      ovf_q   <= '0;
      match_q <= '0;
      last_q  <= '0;
      state_q <= ST_RUN;
      rd_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
      last_q  <= last_d;
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_data = rd_q;
  assign ovf     = ovf_q;
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default 32-bit instance plus an 8-bit
// instance sharing the same stimulus, used for wrap/saturate overflow cases.
module tb_perf_monitor;

  logic        CLK = 1'b0;
  logic        nrst, en, clr, sat_mode, inst_valid;
  logic [15:0] evt_inc;
  logic [31:0] inst;
  logic [3:0]  rd_addr;
  logic [31:0] rd32;
  logic [8:0]  ovf32;
  logic        done32;
  logic [7:0]  rd8;
  logic [8:0]  ovf8;
  logic        done8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  perf_monitor u_dut32 (
    .CLK(CLK), .nrst(nrst), .en(en), .clr(clr), .sat_mode(sat_mode),
    .evt_inc(evt_inc), .inst(inst), .inst_valid(inst_valid),
    .rd_addr(rd_addr), .rd_data(rd32), .ovf(ovf32), .done(done32)
  );

  perf_monitor #(.CNT_W(8)) u_dut8 (
    .CLK(CLK), .nrst(nrst), .en(en), .clr(clr), .sat_mode(sat_mode),
    .evt_inc(evt_inc), .inst(inst), .inst_valid(inst_valid),
    .rd_addr(rd_addr), .rd_data(rd8), .ovf(ovf8), .done(done8)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Select an address, let one edge load rd_data.
  task automatic rd(input logic [3:0] a);
    rd_addr = a;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; en = 1'b0; clr = 1'b0; sat_mode = 1'b0; inst_valid = 1'b0;
    evt_inc = '0; inst = '0; rd_addr = '0;
    step(2);
    chk("reset_rd", rd32, 0);
    chk("reset_ovf", ovf32, 0);
    chk("reset_done", done32, 0);

    // 1: ten enabled cycles, channel 0 +1
    nrst = 1'b1; en = 1'b1; inst_valid = 1'b1; evt_inc = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      inst = 32'h100 + i;
      step();
    end
    en = 1'b0; evt_inc = '0;
    rd(4'd0); chk("t1_cnt0", rd32, 10);
    rd(4'd8); chk("t1_cycles", rd32, 10);
    chk("t1_ovf", ovf32, 0);
    chk("t1_done", done32, 0);

    // 2: ch1 +2 for 5 cycles, ch2 +3 for 4 cycles
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst = 32'h200 + i;
      evt_inc = (i < 4) ? 16'h0038 : 16'h0008;
      step();
    end
    en = 1'b0; evt_inc = '0;
    rd(4'd1);  chk("t2_cnt1", rd32, 10);
    rd(4'd2);  chk("t2_cnt2", rd32, 12);
    rd(4'd0);  chk("t2_cnt0", rd32, 10);
    rd(4'd8);  chk("t2_cycles", rd32, 15);
    rd(4'd9);  chk("t2_adj_floor", rd32, 0);
    rd(4'd10); chk("t2_addr10", rd32, 0);
    rd(4'd15); chk("t2_addr15", rd32, 0);

    // 3: 257 increments on the 8-bit instance, wrap then saturate
    clr = 1'b1; step(); clr = 1'b0;
    sat_mode = 1'b0; en = 1'b1; evt_inc = 16'h0001;
    for (int i = 0; i < 257; i++) begin
      inst = 32'h3000 + i;
      step();
    end
    en = 1'b0; evt_inc = '0;
    rd(4'd0); chk("t3_wrap_cnt0", rd8, 1);
    chk("t3_wrap_ovf", ovf8, 9'h101);
    rd(4'd8); chk("t3_wrap_cycles", rd8, 1);

    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_clr_ovf", ovf8, 0);
    sat_mode = 1'b1; en = 1'b1; evt_inc = 16'h0001;
    for (int i = 0; i < 257; i++) begin
      inst = 32'h3200 + i;
      step();
    end
    en = 1'b0; evt_inc = '0;
    rd(4'd0); chk("t3_sat_cnt0", rd8, 255);
    chk("t3_wide_cnt0", rd32, 257);
    chk("t3_sat_ovf", ovf8, 9'h101);
    chk("t3_wide_ovf", ovf32, 0);
    rd(4'd9); chk("t3_sat_adj", rd8, 205);

    // 4: completion after 100 distinct + 51 held instructions
    clr = 1'b1; step(); clr = 1'b0;
    sat_mode = 1'b0; en = 1'b1; evt_inc = 16'h0001;
    for (int i = 0; i < 100; i++) begin
      inst = 32'h4000 + i;
      step();
    end
    inst = 32'h0000_0013;
    step(50);
    chk("t4_done_pre", done32, 0);
    step();
    chk("t4_done", done32, 1);
    rd(4'd8); chk("t4_cycles", rd32, 151);
    rd(4'd9); chk("t4_adj", rd32, 101);
    rd(4'd0); chk("t4_cnt0", rd32, 151);
    step(20);
    rd(4'd8); chk("t4_frozen_cycles", rd32, 151);
    rd(4'd0); chk("t4_frozen_cnt0", rd32, 151);
    chk("t4_done_hold", done32, 1);

    // 5: clr while done; rd_data on that edge still sees pre-clear count
    rd_addr = 4'd0;
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_done", done32, 0);
    chk("t5_ovf", ovf32, 0);
    chk("t5_rd_preclr", rd32, 151);
    rd(4'd0); chk("t5_cnt0_zero", rd32, 0);
    rd(4'd8); chk("t5_resume", rd32, 1);

    // clr on the edge that would reach the threshold wins
    clr = 1'b1; step(); clr = 1'b0;
    step(50);
    chk("clr_match_pre", done32, 0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_match_done", done32, 0);
    step();
    chk("clr_match_after", done32, 0);

    // 6: reset mid-run with cnt0 = 37
    clr = 1'b1; en = 1'b0; step(); clr = 1'b0;
    en = 1'b1; evt_inc = 16'h0001;
    for (int i = 0; i < 37; i++) begin
      inst = 32'h6000 + i;
      step();
    end
    en = 1'b0;
    rd(4'd0); chk("t6_cnt0", rd32, 37);
    en = 1'b1; nrst = 1'b0;
    step();
    chk("t6_rst_rd", rd32, 0);
    chk("t6_rst_ovf", ovf32, 0);
    chk("t6_rst_done", done32, 0);
    nrst = 1'b1;
    rd(4'd8); chk("t6_cycles0", rd32, 0);
    step();   chk("t6_cycles1", rd32, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
